// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared definitions for the risc_core accumulator CPU:
//               opcode encodings, FSM state encoding, ALU operation
//               encoding and the opcode-to-ALU-op mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

  // 3-bit opcode field, taken from the top bits of the instruction word
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEM    = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_XOR  = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_e;

  // Opcodes without an arithmetic meaning map to PASS; their result is unused.
  function automatic alu_op_e alu_op_of(input logic [2:0] opc);
    case (opc)
      OP_ADD:  return ALU_ADD;
      OP_AND:  return ALU_AND;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc_if.sv
`default_nettype none
// ============================================================================
// Module      : risc_if
// Description : Ready/valid memory port shared by instructions and data.
//               master : the core (drives request, address, write data)
//               slave  : the memory (drives read data and ready)
// Signals     : mem_req, mem_we, mem_addr[ADDR_W], mem_wdata[DATA_W]
//               (master->slave); mem_rdata[DATA_W], mem_ready (slave->master)
// Revision    : 1.0 - initial release
// ============================================================================
interface risc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/risc_alu.sv
`default_nettype none
// ============================================================================
// Module      : risc_alu
// Description : Combinational ALU for the accumulator core.
// Ports       : op_i     - ALU operation (ADD/AND/XOR/PASS)
//               a_i      - accumulator operand
//               b_i      - memory operand
//               result_o - operation result
//               carry_o  - carry out of the addition (meaningful for ADD)
// Revision    : 1.0 - initial release
// ============================================================================
module risc_alu
  import risc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    carry_o  = sum[DATA_W];
    result_o = b_i;
    case (op_i)
      ALU_ADD:  result_o = sum[DATA_W-1:0];
      ALU_AND:  result_o = a_i & b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_PASS: result_o = b_i;
      default:  result_o = b_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/risc_core.sv
`default_nettype none
// ============================================================================
// Module      : risc_core
// Description : Multi-cycle accumulator CPU. Fetches instructions and
//               operands over one ready/valid memory port, executes an
//               8-opcode ISA, supports HALT/restart, a carry flag and a
//               retired-instruction counter.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               start      - pulse, resumes execution from HALT
//               mem        - memory port (risc_if master)
//               halted     - core is in HALT
//               pc         - program counter
//               acc        - accumulator
//               carry      - carry out of last ADD
//               is_zero    - acc == 0 (combinational)
//               retire_cnt - completed non-HLT instructions (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module risc_core
  import risc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  risc_if.master            mem,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              is_zero,
  output logic [CNT_W-1:0]  retire_cnt
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] ir_q;
  logic              carry_q;
  logic [CNT_W-1:0]  retire_q;
  logic              halted_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] skz_pc_d;
  logic [CNT_W-1:0]  retire_d;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  assign opcode   = ir_q[DATA_W-1 -: 3];
  assign operand  = ir_q[ADDR_W-1:0];
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign skz_pc_d = (acc_q == '0) ? pc_inc : pc_q;
  assign retire_d = retire_q + CNT_W'(1);
  assign alu_op   = alu_op_of(opcode);

  risc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i     (alu_op),
    .a_i      (acc_q),
    .b_i      (mem.mem_rdata),
    .result_o (alu_result),
    .carry_o  (alu_carry)
  );

  // Request, address and direction are registered and only change on the
  // edge that completes an access (or starts the next one), so they stay
  // stable for the whole wait period. Write data is the accumulator, which
  // cannot change while a STO is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      acc_q    <= '0;
      ir_q     <= '0;
      carry_q  <= 1'b0;
      retire_q <= '0;
      halted_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            // Only reached straight after reset: issue the first fetch.
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= pc_q;
          end else if (mem.mem_ready) begin
            ir_q    <= mem.mem_rdata;
            pc_q    <= pc_inc;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_HLT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            OP_JMP: begin
              pc_q     <= operand;
              retire_q <= retire_d;
              req_q    <= 1'b1;
              we_q     <= 1'b0;
              addr_q   <= operand;
              state_q  <= S_FETCH;
            end
            OP_SKZ: begin
              pc_q     <= skz_pc_d;
              retire_q <= retire_d;
              req_q    <= 1'b1;
              we_q     <= 1'b0;
              addr_q   <= skz_pc_d;
              state_q  <= S_FETCH;
            end
            OP_STO: begin
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= operand;
              state_q <= S_MEM;
            end
            default: begin
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= operand;
              state_q <= S_MEM;
            end
          endcase
        end

        S_MEM: begin
          if (mem.mem_ready) begin
            if (!we_q) begin
              acc_q <= alu_result;
              if (opcode == OP_ADD) begin
                carry_q <= alu_carry;
              end
            end
            retire_q <= retire_d;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= pc_q;
            state_q  <= S_FETCH;
          end
        end

        S_HALT: begin
          if (start) begin
            halted_q <= 1'b0;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= pc_q;
            state_q  <= S_FETCH;
          end
        end

        default: begin
          state_q <= S_FETCH;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = acc_q;

  assign halted     = halted_q;
  assign pc         = pc_q;
  assign acc        = acc_q;
  assign carry      = carry_q;
  assign is_zero    = (acc_q == '0);
  assign retire_cnt = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_core
// Description : Self-checking bench for risc_core. A behavioural memory
//               with programmable wait states answers the core; expected
//               writes and fetch addresses are queued when a program is
//               loaded and compared against the accesses the core makes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_core;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          halted;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic          carry;
  logic          is_zero;
  logic [CW-1:0] retire_cnt;

  risc_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

  risc_core #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem        (mif),
    .halted     (halted),
    .pc         (pc),
    .acc        (acc),
    .carry      (carry),
    .is_zero    (is_zero),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [32];
  int            wait_cycles = 0;
  bit            noready = 1'b0;
  int            wcnt = 0;
  wr_t           wr_log [$];
  logic [AW-1:0] rd_log [$];
  wr_t           exp_wr [$];
  logic [AW-1:0] exp_rd [$];

  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
  end

  always @(negedge clk) begin
    mif.mem_ready = mif.mem_req && !noready && (wcnt >= wait_cycles);
    mif.mem_rdata = mem[mif.mem_addr];
  end

  always @(posedge clk) begin
    if (rst || !mif.mem_req) begin
      wcnt = 0;
    end else if (mif.mem_ready) begin
      wcnt = 0;
      if (mif.mem_we) begin
        mem[mif.mem_addr] = mif.mem_wdata;
        wr_log.push_back('{a: mif.mem_addr, d: mif.mem_wdata});
      end else begin
        rd_log.push_back(mif.mem_addr);
      end
    end else begin
      wcnt = wcnt + 1;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    wr_log.delete(); rd_log.delete(); exp_wr.delete(); exp_rd.delete();
  endtask

  // Resets the core, lets it run, measures cycles from first request to
  // halted and checks that a waiting request holds address/we/wdata.
  task automatic run_program(input int ws, output int lat);
    int first;
    bit p_req, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd;
    wait_cycles = ws;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_log.delete(); rd_log.delete();
    first = -1; lat = -1; p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (mif.mem_req && first < 0) first = c;
      if (p_req && !mif.mem_ready && mif.mem_req) begin
        vectors++;
        if ({mif.mem_addr, mif.mem_we, mif.mem_wdata} !== {p_addr, p_we, p_wd}) begin
          miscompares++;
          $display("FAIL hold_stable: got addr=%0d we=%0b wdata=%h, required addr=%0d we=%0b wdata=%h",
                   mif.mem_addr, mif.mem_we, mif.mem_wdata, p_addr, p_we, p_wd);
        end
      end
      p_req = mif.mem_req; p_we = mif.mem_we; p_addr = mif.mem_addr; p_wd = mif.mem_wdata;
      if (halted) begin
        lat = c - first;
        break;
      end
    end
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: core did not halt within 400 cycles");
    end
  endtask

  task automatic check_writes(input string name);
    wr_t e, a;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      vectors++;
      if (wr_log.size() == 0) begin
        miscompares++;
        $display("FAIL %s_write: got no write, required addr=%0d data=%h", name, e.a, e.d);
      end else begin
        a = wr_log.pop_front();
        if (a !== e) begin
          miscompares++;
          $display("FAIL %s_write: got addr=%0d data=%h, required addr=%0d data=%h", name, a.a, a.d, e.a, e.d);
        end
      end
    end
    vectors++;
    if (wr_log.size() != 0) begin
      miscompares++;
      $display("FAIL %s_extra_writes: got %0d unexpected writes, required 0", name, wr_log.size());
    end
  endtask

  task automatic check_reads(input string name);
    logic [AW-1:0] e, a;
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      vectors++;
      a = (rd_log.size() > 0) ? rd_log.pop_front() : 'x;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s_read_addr: got %0d, required %0d", name, a, e);
      end
    end
  endtask

  task automatic check_final(input string name, input logic [AW-1:0] e_pc, input logic [DW-1:0] e_acc,
                             input logic e_carry, input logic [CW-1:0] e_ret);
    vectors++;
    if ({halted, pc, acc, carry, retire_cnt} !== {1'b1, e_pc, e_acc, e_carry, e_ret}) begin
      miscompares++;
      $display("FAIL %s_final: got halted=%0b pc=%0d acc=%h carry=%0b retire=%0d, required halted=1 pc=%0d acc=%h carry=%0b retire=%0d",
               name, halted, pc, acc, carry, retire_cnt, e_pc, e_acc, e_carry, e_ret);
    end
  endtask

  task automatic load_arith();
    clear_mem();
    mem[0] = 8'hBE; mem[1] = 8'h5F; mem[2] = 8'hDD; mem[3] = 8'h00;
    mem[30] = 8'hF0; mem[31] = 8'h20;
    exp_wr.push_back('{a: 5'd29, d: 8'h10});
    exp_rd.push_back(5'd0); exp_rd.push_back(5'd30); exp_rd.push_back(5'd1);
    exp_rd.push_back(5'd31); exp_rd.push_back(5'd2); exp_rd.push_back(5'd3);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; noready = 1'b0; wait_cycles = 0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({mif.mem_req, pc, acc, carry, halted, retire_cnt, is_zero} !== {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: got req=%0b pc=%0d acc=%h carry=%0b halted=%0b retire=%0d zero=%0b, required 0 0 00 0 0 0 1",
               mif.mem_req, pc, acc, carry, halted, retire_cnt, is_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {1'b1, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_first_fetch: got req=%0b we=%0b addr=%0d, required req=1 we=0 addr=0",
               mif.mem_req, mif.mem_we, mif.mem_addr);
    end
  endtask

  task automatic test_arith();
    int lat;
    load_arith();
    run_program(0, lat);
    check_final("arith", 5'd4, 8'h10, 1'b1, 16'd3);
    check_writes("arith");
    check_reads("arith");
    vectors++;
    if (lat !== 11) begin
      miscompares++;
      $display("FAIL arith_latency: got %0d cycles, required 11", lat);
    end
  endtask

  task automatic test_restart();
    mem[4] = 8'hBE; mem[5] = 8'h00;
    exp_rd.push_back(5'd4); exp_rd.push_back(5'd30); exp_rd.push_back(5'd5);
    wait_cycles = 2;
    rd_log.delete();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({halted, mif.mem_req, pc} !== {1'b1, 1'b0, 5'd4}) begin
      miscompares++;
      $display("FAIL halt_hold: got halted=%0b req=%0b pc=%0d, required halted=1 req=0 pc=4", halted, mif.mem_req, pc);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if ({halted, mif.mem_req, mif.mem_addr} !== {1'b0, 1'b1, 5'd4}) begin
      miscompares++;
      $display("FAIL restart_fetch: got halted=%0b req=%0b addr=%0d, required halted=0 req=1 addr=4", halted, mif.mem_req, mif.mem_addr);
    end
    // Hold start high during every FETCH/MEM cycle; the core must ignore it.
    for (int c = 0; c < 60 && !halted; c++) begin
      start = mif.mem_req;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    check_final("restart", 5'd6, 8'hF0, 1'b1, 16'd4);
    check_reads("restart");
  endtask

  task automatic test_reset_mid_access();
    noready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({mif.mem_req, mif.mem_addr} !== {1'b1, 5'd6}) begin
      miscompares++;
      $display("FAIL midacc_pending: got req=%0b addr=%0d, required req=1 addr=6", mif.mem_req, mif.mem_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({mif.mem_req, pc, acc, carry, retire_cnt} !== {1'b0, 5'd0, 8'h00, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL midacc_reset: got req=%0b pc=%0d acc=%h carry=%0b retire=%0d, required 0 0 00 0 0",
               mif.mem_req, pc, acc, carry, retire_cnt);
    end
    @(posedge clk); #1;
    vectors++;
    if ({mif.mem_req, mif.mem_addr} !== {1'b1, 5'd0}) begin
      miscompares++;
      $display("FAIL midacc_refetch: got req=%0b addr=%0d, required req=1 addr=0", mif.mem_req, mif.mem_addr);
    end
    noready = 1'b0;
  endtask

  task automatic test_wait_states();
    int lat;
    load_arith();
    run_program(3, lat);
    check_final("wait", 5'd4, 8'h10, 1'b1, 16'd3);
    check_writes("wait");
    check_reads("wait");
    // Seven accesses (four fetches, three operand accesses) each stretched by 3.
    vectors++;
    if (lat !== 11 + 7 * 3) begin
      miscompares++;
      $display("FAIL wait_latency: got %0d cycles, required %0d", lat, 11 + 7 * 3);
    end
  endtask

  task automatic test_pc_wrap_skz();
    int lat;
    clear_mem();
    mem[0] = 8'hFF; mem[31] = 8'h20; mem[1] = 8'h00; mem[2] = 8'hBE;
    exp_rd.push_back(5'd0); exp_rd.push_back(5'd31); exp_rd.push_back(5'd1);
    run_program(0, lat);
    check_final("wrap", 5'd2, 8'h00, 1'b0, 16'd2);
    check_reads("wrap");
    vectors++;
    if (is_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_is_zero: got %0b, required 1", is_zero);
    end
  endtask

  task automatic test_skz_not_taken();
    int lat;
    clear_mem();
    mem[0] = 8'hBE; mem[1] = 8'h20; mem[2] = 8'h00; mem[30] = 8'h01;
    mem[3] = 8'hBF; mem[31] = 8'h55;
    run_program(1, lat);
    check_final("skz_nt", 5'd3, 8'h01, 1'b0, 16'd2);
    mem[30] = 8'h00; mem[4] = 8'h00;
    exp_rd.push_back(5'd0); exp_rd.push_back(5'd30); exp_rd.push_back(5'd1);
    exp_rd.push_back(5'd3); exp_rd.push_back(5'd31); exp_rd.push_back(5'd4);
    run_program(0, lat);
    check_final("skz_t", 5'd5, 8'h55, 1'b0, 16'd3);
    check_reads("skz_t");
  endtask

  task automatic test_logic_ops();
    int lat;
    clear_mem();
    // LDA 30 (FF); ADD 31 (+01 -> 00, carry); XOR 30 (FF); AND 28 (3C); STO 27; HLT
    mem[0] = 8'hBE; mem[1] = 8'h5F; mem[2] = 8'h9E; mem[3] = 8'h7C; mem[4] = 8'hDB; mem[5] = 8'h00;
    mem[28] = 8'h3C; mem[30] = 8'hFF; mem[31] = 8'h01;
    exp_wr.push_back('{a: 5'd27, d: 8'h3C});
    run_program(0, lat);
    check_final("logic", 5'd6, 8'h3C, 1'b1, 16'd5);
    check_writes("logic");
    vectors++;
    if (is_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL logic_is_zero: got %0b, required 0", is_zero);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_restart();
    test_reset_mid_access();
    test_wait_states();
    test_pc_wrap_skz();
    test_skz_not_taken();
    test_logic_ops();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
